// File: rtl/m_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : m_ram_arb
// Description : Two-master arbiter in front of the single SPRAM slave port.
//               Master 0 is the core, master 1 a secondary bus master.
//               One grant at a time, held until the slave acknowledges, with
//               one IDLE bubble between grants.
//               Build option M_RAM_ARB_RR_EN: round-robin tie-break
//               (undefined: fixed priority, M0 wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
module m_ram_arb #(
    parameter int ADRW = 17
) (
    input  logic            CLK_I,
    input  logic            RST_N_I,
    input  logic            M0_STB_I,
    input  logic            M0_WE_I,
    input  logic [ADRW-1:0] M0_ADR_I,
    input  logic [3:0]      M0_SEL_I,
    input  logic [31:0]     M0_DAT_I,
    output logic [31:0]     M0_DAT_O,
    output logic            M0_ACK_O,
    input  logic            M1_STB_I,
    input  logic            M1_WE_I,
    input  logic [ADRW-1:0] M1_ADR_I,
    input  logic [3:0]      M1_SEL_I,
    input  logic [31:0]     M1_DAT_I,
    output logic [31:0]     M1_DAT_O,
    output logic            M1_ACK_O,
    output logic            S_STB_O,
    output logic            S_WE_O,
    output logic [ADRW-1:0] S_ADR_O,
    output logic [3:0]      S_SEL_O,
    output logic [31:0]     S_DAT_O,
    input  logic [31:0]     S_DAT_I,
    input  logic            S_ACK_I,
    output logic [1:0]      GNT_O
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_pick0;

`ifdef M_RAM_ARB_RR_EN
    // High when master 1 was the most recently granted master.
    logic r_last;

    // Remember who was granted last; updated only on entry to a grant state.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            r_last <= 1'b1;
        end else if (r_state == ST_IDLE && w_next == ST_GNT0) begin
            r_last <= 1'b0;
        end else if (r_state == ST_IDLE && w_next == ST_GNT1) begin
            r_last <= 1'b1;
        end
    end

    // M0 wins if alone, or on a tie when M1 was served last.
    assign w_pick0 = M0_STB_I && (!M1_STB_I || r_last);
`else
    // Fixed priority: any M0 request wins.
    assign w_pick0 = M0_STB_I;
`endif

    // State register.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and slave/master muxing; outputs are forced idle while
    // reset is asserted so a grant interrupted by reset never acknowledges.
    always_comb begin
        w_next   = r_state;
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_ADR_O  = '0;
        S_SEL_O  = 4'b0000;
        S_DAT_O  = 32'h0000_0000;
        M0_ACK_O = 1'b0;
        M1_ACK_O = 1'b0;
        GNT_O    = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_pick0) begin
                    w_next = ST_GNT0;
                end else if (M1_STB_I) begin
                    w_next = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!M0_STB_I || S_ACK_I) begin
                    w_next = ST_IDLE;
                end
                if (RST_N_I) begin
                    GNT_O    = 2'b01;
                    S_STB_O  = M0_STB_I;
                    S_WE_O   = M0_WE_I;
                    S_ADR_O  = M0_ADR_I;
                    S_SEL_O  = M0_SEL_I;
                    S_DAT_O  = M0_DAT_I;
                    // An abandoned cycle must not see a late slave ACK.
                    M0_ACK_O = S_ACK_I && M0_STB_I;
                end
            end
            ST_GNT1: begin
                if (!M1_STB_I || S_ACK_I) begin
                    w_next = ST_IDLE;
                end
                if (RST_N_I) begin
                    GNT_O    = 2'b10;
                    S_STB_O  = M1_STB_I;
                    S_WE_O   = M1_WE_I;
                    S_ADR_O  = M1_ADR_I;
                    S_SEL_O  = M1_SEL_I;
                    S_DAT_O  = M1_DAT_I;
                    M1_ACK_O = S_ACK_I && M1_STB_I;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Read data goes to both masters; only the owner's ACK qualifies it.
    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;

endmodule
`default_nettype wire

// File: tb/tb_m_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_ram_arb
// Description : Self-checking bench for m_ram_arb with a behavioural SPRAM
//               slave (write acks combinationally, read acks one cycle after
//               strobe) and a word-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_ram_arb;

    localparam int ADRW = 17;

    logic            CLK_I = 1'b0;
    logic            RST_N_I;
    logic [1:0]      m_stb;
    logic [1:0]      m_we;
    logic [ADRW-1:0] m_adr [2];
    logic [3:0]      m_sel [2];
    logic [31:0]     m_dat [2];
    logic [31:0]     m_dato [2];
    logic [1:0]      m_ack;
    logic            S_STB_O, S_WE_O;
    logic [ADRW-1:0] S_ADR_O;
    logic [3:0]      S_SEL_O;
    logic [31:0]     S_DAT_O;
    logic [31:0]     S_DAT_I;
    logic            S_ACK_I;
    logic [1:0]      GNT_O;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    always #5 CLK_I = ~CLK_I;

    m_ram_arb #(.ADRW(ADRW)) dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I),
        .M0_STB_I(m_stb[0]), .M0_WE_I(m_we[0]), .M0_ADR_I(m_adr[0]),
        .M0_SEL_I(m_sel[0]), .M0_DAT_I(m_dat[0]), .M0_DAT_O(m_dato[0]), .M0_ACK_O(m_ack[0]),
        .M1_STB_I(m_stb[1]), .M1_WE_I(m_we[1]), .M1_ADR_I(m_adr[1]),
        .M1_SEL_I(m_sel[1]), .M1_DAT_I(m_dat[1]), .M1_DAT_O(m_dato[1]), .M1_ACK_O(m_ack[1]),
        .S_STB_O(S_STB_O), .S_WE_O(S_WE_O), .S_ADR_O(S_ADR_O), .S_SEL_O(S_SEL_O),
        .S_DAT_O(S_DAT_O), .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I), .GNT_O(GNT_O)
    );

    // ---------------- SPRAM slave model ----------------
    logic [31:0] ram [0:32767];
    logic        rd_pend = 1'b0;
    logic        inj_ack = 1'b0;
    logic [31:0] rd_q = 32'h0;

    assign S_ACK_I = (S_STB_O && S_WE_O) || rd_pend || inj_ack;
    assign S_DAT_I = rd_q;

    always @(posedge CLK_I) begin
        rd_pend <= S_STB_O && !S_WE_O && !rd_pend;
        if (S_STB_O && !S_WE_O) rd_q <= ram[S_ADR_O[16:2]];
        if (S_STB_O && S_WE_O) begin
            for (int b = 0; b < 4; b++)
                if (S_SEL_O[b]) ram[S_ADR_O[16:2]][8*b +: 8] <= S_DAT_O[8*b +: 8];
        end
    end

    // ---------------- reference memory ----------------
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic void ref_write(input logic [ADRW-1:0] adr, input logic [31:0] dat,
                                      input logic [3:0] sel);
        int w = int'(adr >> 2);
        logic [31:0] old = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
        ref_mem[w] = (old & ~sel_mask(sel)) | (dat & sel_mask(sel));
    endfunction

    // Only the owner may see ACK, and never both at once.
    always @(negedge CLK_I) begin
        if (mon_en && RST_N_I === 1'b1) begin
            n_cmp++;
            if ((m_ack[0] && m_ack[1]) || (m_ack[0] && GNT_O !== 2'b01) ||
                (m_ack[1] && GNT_O !== 2'b10)) begin
                n_bad++;
                $display("FAIL ack_routing: ack=%b gnt=%b", m_ack, GNT_O);
            end
        end
    end

    // One transfer from master m; call and return aligned 1 ns after posedge.
    task automatic xfer(input int m, input bit we, input logic [ADRW-1:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input bit chk_lat,
                        output logic [31:0] rdat);
        int lat = 0;
        bit got = 0;
        logic [1:0] exp_g = (m == 0) ? 2'b01 : 2'b10;
        m_we[m] = we; m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel; m_stb[m] = 1'b1;
        rdat = 32'h0;
        @(posedge CLK_I);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK_I);
            lat++;
            if (m_ack[m]) begin
                got = 1;
                rdat = m_dato[m];
                n_cmp++;
                if (GNT_O !== exp_g || S_ADR_O !== adr || S_WE_O !== we) begin
                    n_bad++;
                    $display("FAIL slave_mux m%0d: gnt=%b adr=%h we=%b want gnt=%b adr=%h we=%b",
                             m, GNT_O, S_ADR_O, S_WE_O, exp_g, adr, we);
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL ack_timeout m%0d: no ack within 60 cycles", m);
        end
        if (chk_lat && got) begin
            n_cmp++;
            if (lat != (we ? 1 : 2)) begin
                n_bad++;
                $display("FAIL latency m%0d we=%0d: got %0d cycles want %0d", m, we, lat, we ? 1 : 2);
            end
        end
        if (got && we) ref_write(adr, dat, sel);
        if (got && !we) begin
            n_cmp++;
            if (rdat !== ref_mem[int'(adr >> 2)]) begin
                n_bad++;
                $display("FAIL read_data m%0d adr=%h: got %h want %h", m, adr, rdat,
                         ref_mem[int'(adr >> 2)]);
            end
        end
        @(posedge CLK_I);
        #1;
        m_stb[m] = 1'b0;
    endtask

    task automatic do_reset();
        RST_N_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #1;
        RST_N_I = 1'b1;
    endtask

    task automatic test_reset();
        RST_N_I = 1'b0;
        m_stb = 2'b01; m_we = 2'b01;
        m_adr[0] = 17'h0_0008; m_dat[0] = 32'h11223344; m_sel[0] = 4'hF;
        repeat (3) begin
            @(negedge CLK_I);
            n_cmp++;
            if (S_STB_O !== 1'b0 || S_WE_O !== 1'b0 || GNT_O !== 2'b00 || m_ack !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_hold: stb=%b we=%b gnt=%b ack=%b want all 0",
                         S_STB_O, S_WE_O, GNT_O, m_ack);
            end
        end
        @(posedge CLK_I); #1;
        RST_N_I = 1'b1;
        mon_en = 1'b1;
        @(negedge CLK_I);
        n_cmp++;
        if (GNT_O !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release_idle: gnt=%b want 00", GNT_O);
        end
        @(negedge CLK_I);
        n_cmp++;
        if (GNT_O !== 2'b01 || m_ack[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL first_grant: gnt=%b ack0=%b want 01/1", GNT_O, m_ack[0]);
        end
        ref_write(17'h0_0008, 32'h11223344, 4'hF);
        @(posedge CLK_I); #1;
        m_stb[0] = 1'b0;
        // Reset asserted in the middle of a read grant: no ACK may appear.
        m_we[0] = 1'b0; m_stb[0] = 1'b1;
        @(posedge CLK_I); #1;
        RST_N_I = 1'b0;
        repeat (2) begin
            @(negedge CLK_I);
            n_cmp++;
            if (m_ack !== 2'b00 || S_STB_O !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid_grant: ack=%b stb=%b want 00/0", m_ack, S_STB_O);
            end
        end
        @(posedge CLK_I); #1;
        m_stb[0] = 1'b0;
        RST_N_I = 1'b1;
        @(negedge CLK_I);
        n_cmp++;
        if (GNT_O !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_grant_idle: gnt=%b want 00", GNT_O);
        end
        @(posedge CLK_I); #1;
    endtask

    task automatic test_single_write();
        logic [31:0] r;
        xfer(1, 1'b1, 17'h1_0004, 32'hDEADBEEF, 4'b1111, 1'b1, r);
        xfer(0, 1'b0, 17'h1_0004, 32'h0, 4'b1111, 1'b1, r);
        n_cmp++;
        if (r !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL single_write_readback: got %h want deadbeef", r);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] r;
        xfer(0, 1'b1, 17'h0_0040, 32'h11223344, 4'b1111, 1'b1, r);
        xfer(0, 1'b1, 17'h0_0040, 32'h0000AB00, 4'b0010, 1'b1, r);
        xfer(1, 1'b0, 17'h0_0040, 32'h0, 4'b1111, 1'b1, r);
        n_cmp++;
        if (r !== 32'h1122AB44) begin
            n_bad++;
            $display("FAIL byte_write: got %h want 1122ab44", r);
        end
    endtask

    task automatic test_tie();
        logic [1:0] exp_g;
        int ack1 = 0;
        do_reset();
        m_we = 2'b00;
        m_adr[0] = 17'h0_0008; m_adr[1] = 17'h0_0008;
        m_sel[0] = 4'hF; m_sel[1] = 4'hF;
        m_stb = 2'b11;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK_I);
            if (m_ack[1]) ack1++;
            if (i == 0 || (i - 1) % 3 == 2) exp_g = 2'b00;
`ifdef M_RAM_ARB_RR_EN
            else exp_g = (((i - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
`else
            else exp_g = 2'b01;
`endif
            n_cmp++;
            if (GNT_O !== exp_g) begin
                n_bad++;
                $display("FAIL tie_grant[%0d]: gnt=%b want %b", i, GNT_O, exp_g);
            end
        end
        n_cmp++;
`ifdef M_RAM_ARB_RR_EN
        if (ack1 != 2) begin
            n_bad++;
            $display("FAIL tie_m1_acks: got %0d want 2", ack1);
        end
`else
        if (ack1 != 0) begin
            n_bad++;
            $display("FAIL tie_m1_acks: got %0d want 0", ack1);
        end
`endif
        @(posedge CLK_I); #1;
        m_stb = 2'b00;
        repeat (3) @(posedge CLK_I);
        #1;
    endtask

    task automatic test_contention();
        logic [31:0] r0, r1;
        logic [1:0]  exp_seq [6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
        fork
            xfer(0, 1'b0, 17'h1_0004, 32'h0, 4'hF, 1'b1, r0);
            begin
                @(posedge CLK_I); #1;
                xfer(1, 1'b1, 17'h0_0100, $urandom, 4'hF, 1'b0, r1);
            end
            for (int i = 0; i < 6; i++) begin
                @(negedge CLK_I);
                n_cmp++;
                if (GNT_O !== exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL contention_seq[%0d]: gnt=%b want %b", i, GNT_O, exp_seq[i]);
                end
            end
        join
    endtask

    task automatic test_abandon();
        logic [31:0] r;
        logic [31:0] d = $urandom;
        m_we[0] = 1'b0; m_adr[0] = 17'h0_0008; m_sel[0] = 4'hF; m_stb[0] = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        m_stb[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) inj_ack = 1'b1;
            @(negedge CLK_I);
            n_cmp++;
            if (m_ack !== 2'b00) begin
                n_bad++;
                $display("FAIL abandon_no_ack[%0d]: ack=%b want 00", i, m_ack);
            end
            @(posedge CLK_I); #1;
            inj_ack = 1'b0;
        end
        xfer(1, 1'b1, 17'h0_0200, d, 4'hF, 1'b1, r);
        xfer(1, 1'b0, 17'h0_0200, 32'h0, 4'hF, 1'b1, r);
    endtask

    task automatic test_random_seq();
        logic [31:0] r;
        bit wr [8] = '{default: 1'b0};
        for (int n = 0; n < 30; n++) begin
            int m = $urandom_range(0, 1);
            int k = $urandom_range(0, 7);
            bit we = !wr[k] || ($urandom_range(0, 1) == 1);
            logic [3:0] sel = wr[k] ? 4'($urandom_range(1, 15)) : 4'hF;
            xfer(m, we, 17'h0_2000 + 17'(4 * k), $urandom, sel, 1'b1, r);
            if (we) wr[k] = 1'b1;
        end
    endtask

    task automatic worker(input int m);
        logic [31:0] r;
        bit wr [4] = '{default: 1'b0};
        for (int n = 0; n < 12; n++) begin
            int k = $urandom_range(0, 3);
            int g = (m == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            bit we = !wr[k] || ($urandom_range(0, 1) == 1);
            xfer(m, we, 17'h0_3000 + 17'(8 * k + 4 * m), $urandom, wr[k] ? 4'($urandom_range(1, 15)) : 4'hF,
                 1'b0, r);
            if (we) wr[k] = 1'b1;
            if (g > 0) begin
                repeat (g) @(posedge CLK_I);
                #1;
            end
        end
    endtask

    task automatic test_random_concurrent();
        fork
            worker(0);
            worker(1);
        join
    endtask

    initial begin
        m_stb = 2'b00; m_we = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_sel[i] = 4'h0; m_dat[i] = 32'h0;
        end
        test_reset();
        test_single_write();
        test_byte_write();
        test_contention();
        test_abandon();
        test_random_seq();
        test_random_concurrent();
        test_tie();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
